// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster-timing definitions for the VGA/SLM display path.
//   - default 1280x1024 timing parameters and the totals / sync window
//     boundaries derived from them
//   - counter width shared by every block that looks at h_cnt / v_cnt
//   - request FSM state encoding
//   - small helpers that derive totals and sync windows, so parameterised
//     instances compute them exactly the same way as the defaults
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 13;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_ACTIVE   = 1280;
  localparam int DEF_H_FP       = 48;
  localparam int DEF_H_SYNC     = 112;
  localparam int DEF_H_BP       = 248;
  localparam int DEF_V_ACTIVE   = 1024;
  localparam int DEF_V_FP       = 1;
  localparam int DEF_V_SYNC     = 3;
  localparam int DEF_V_BP       = 38;
  localparam int DEF_REQ_CYCLES = 2;

  function automatic int total4(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int syn);
    return act + fp + syn;
  endfunction

  localparam int H_TOTAL      = total4(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = total4(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_t;

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Horizontal / vertical raster counters with active-area and sync decode.
// Ports:
//   clk     in   pixel clock
//   srst    in   synchronous active-high reset (h=0, v=last line)
//   h_cnt   out  current pixel column, 0..H_TOTAL-1
//   v_cnt   out  current line, 0..V_TOTAL-1
//   active  out  inside the visible area (combinational from counters)
//   hs      out  inside the HS window (combinational, not yet registered)
//   vs      out  inside the VS window (combinational, not yet registered)
// ---------------------------------------------------------------------------
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             srst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs
);

  localparam int HT  = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT  = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HSS = sync_start(H_ACTIVE, H_FP);
  localparam int HSE = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VSS = sync_start(V_ACTIVE, V_FP);
  localparam int VSE = sync_end(V_ACTIVE, V_FP, V_SYNC);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(HT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(VT - 1)) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Reset parks on the last line so the line-0 request fires before frame 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      h_cnt_q <= '0;
      v_cnt_q <= CNT_W'(VT - 1);
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;
  assign active = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
  assign hs     = (h_cnt_q >= CNT_W'(HSS)) && (h_cnt_q < CNT_W'(HSE));
  assign vs     = (v_cnt_q >= CNT_W'(VSS)) && (v_cnt_q < CNT_W'(VSE));

endmodule

// File: rtl/vga_line_fetch_timing.sv
// ---------------------------------------------------------------------------
// vga_line_fetch_timing
// Raster timing generator and show-ahead pixel FIFO consumer. Requests each
// upcoming active line from the SDRAM line loader, streams pixels to the DAC
// and flushes the FIFO once per frame at the start of vertical blanking.
// Ports:
//   iCLK                   in   pixel clock
//   iRST                   in   synchronous active-high reset
//   iRDATA[7:0]            in   FIFO show-ahead data
//   iRDEMPTY               in   FIFO empty
//   oRREQ                  out  FIFO pop (combinational: active && !empty)
//   oFIFO_CLR              out  one-clock flush pulse
//   oVGA_LINE_TO_LOAD[12:0] out line index for the loader
//   oVGA_LOAD_TO_FIFO_REQ  out  load request, REQ_CYCLES clocks wide
//   oVGA_DATA[7:0]         out  pixel grey level
//   oVGA_HS / oVGA_VS      out  active-high syncs
//   oVGA_BLANK_N           out  low outside the active area
//   oUNDERFLOW             out  sticky: active pixel with FIFO empty
// All registered outputs share one clock of latency from the counters.
// ---------------------------------------------------------------------------
module vga_line_fetch_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int REQ_CYCLES = DEF_REQ_CYCLES
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iRDATA,
  input  logic        iRDEMPTY,
  output logic        oRREQ,
  output logic        oFIFO_CLR,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  output logic [7:0]  oVGA_DATA,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oUNDERFLOW
);

  localparam int VT   = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // Holds REQ_CYCLES-1, the number of extra clocks the request stays high.
  localparam int RC_W = (REQ_CYCLES > 2) ? $clog2(REQ_CYCLES) : 1;

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic active;
  logic hs_raw;
  logic vs_raw;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk    (iCLK),
    .srst   (iRST),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs     (hs_raw),
    .vs     (vs_raw)
  );

  // Never pop an empty FIFO; popping is tied to the live counter state.
  assign oRREQ = active && !iRDEMPTY;

  // Trigger at the end of active video: request the next active line, or
  // line 0 while sitting on the last line of the frame.
  logic trigger;
  cnt_t next_line;
  logic last_line;

  always_comb begin
    last_line = (v_cnt == CNT_W'(VT - 1));
    trigger   = (h_cnt == CNT_W'(H_ACTIVE)) &&
                ((v_cnt < CNT_W'(V_ACTIVE - 1)) || last_line);
    next_line = last_line ? '0 : v_cnt + 1'b1;
  end

  req_state_t        state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  line_q, line_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    req_d   = req_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = REQ;
          req_d   = 1'b1;
          line_d  = next_line;
          rcnt_d  = RC_W'(REQ_CYCLES - 1);
        end
      end
      REQ: begin
        if (rcnt_q == '0) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      req_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      req_q   <= req_d;
      line_q  <= line_d;
    end
  end

  // Pixel / sync / flush pipeline stage.
  logic [7:0] data_q, data_d;
  logic       blank_n_q, blank_n_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       clr_q, clr_d;
  logic       uf_q, uf_d;

  always_comb begin
    data_d    = (active && !iRDEMPTY) ? iRDATA : 8'h00;
    blank_n_d = active;
    hs_d      = hs_raw;
    vs_d      = vs_raw;
    // Start of vertical blanking; the last request of the frame finished
    // long before, so flush and request never overlap.
    clr_d     = (h_cnt == '0) && (v_cnt == CNT_W'(V_ACTIVE));
    uf_d      = uf_q || (active && iRDEMPTY);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_q    <= 8'h00;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      clr_q     <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      data_q    <= data_d;
      blank_n_q <= blank_n_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      clr_q     <= clr_d;
      uf_q      <= uf_d;
    end
  end

  assign oVGA_DATA             = data_q;
  assign oVGA_BLANK_N          = blank_n_q;
  assign oVGA_HS               = hs_q;
  assign oVGA_VS               = vs_q;
  assign oFIFO_CLR             = clr_q;
  assign oUNDERFLOW            = uf_q;
  assign oVGA_LOAD_TO_FIFO_REQ = req_q;
  assign oVGA_LINE_TO_LOAD     = line_q;

endmodule

// File: tb/tb_vga_line_fetch_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetch_timing
// Bench for vga_line_fetch_timing using a shrunken raster (25x13) so whole
// frames fit in a short run. A background process models the line loader,
// the show-ahead FIFO and the expected output of every clock; each clock it
// pushes one expectation packet that the test tasks pop and compare.
// A second instance with REQ_CYCLES=4 exercises mid-request reset.
// ---------------------------------------------------------------------------
module tb_vga_line_fetch_timing;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int RC = 2,  RC4 = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rdempty = 1'b1;
  logic        oRREQ, oFIFO_CLR, oVGA_LOAD_TO_FIFO_REQ;
  logic [12:0] oVGA_LINE_TO_LOAD;
  logic [7:0]  oVGA_DATA;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oUNDERFLOW;

  logic        rst4 = 1'b1;
  logic [7:0]  rdata4 = 8'h00;
  logic        rdempty4 = 1'b1;
  logic        rreq4, clr4, req4, hs4, vs4, blank4, uf4;
  logic [12:0] line4;
  logic [7:0]  data4;

  vga_line_fetch_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .REQ_CYCLES(RC)
  ) dut (
    .iCLK(clk), .iRST(rst), .iRDATA(rdata), .iRDEMPTY(rdempty),
    .oRREQ(oRREQ), .oFIFO_CLR(oFIFO_CLR), .oVGA_LINE_TO_LOAD(oVGA_LINE_TO_LOAD),
    .oVGA_LOAD_TO_FIFO_REQ(oVGA_LOAD_TO_FIFO_REQ), .oVGA_DATA(oVGA_DATA),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oUNDERFLOW(oUNDERFLOW)
  );

  vga_line_fetch_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .REQ_CYCLES(RC4)
  ) dut4 (
    .iCLK(clk), .iRST(rst4), .iRDATA(rdata4), .iRDEMPTY(rdempty4),
    .oRREQ(rreq4), .oFIFO_CLR(clr4), .oVGA_LINE_TO_LOAD(line4),
    .oVGA_LOAD_TO_FIFO_REQ(req4), .oVGA_DATA(data4),
    .oVGA_HS(hs4), .oVGA_VS(vs4), .oVGA_BLANK_N(blank4),
    .oUNDERFLOW(uf4)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]  data;
    logic        blank, hs, vs, clr, req, uf;
    logic [12:0] line;
    int          h, v;
    logic        rreq_exp, rreq_obs;
  } pkt_t;

  pkt_t       sb[$];
  logic [7:0] fifo[$];
  int         starve_line = -1;

  // Reference model: counter state mh/mv is the DUT counter value between
  // edges. At negedge+2 it drives FIFO inputs, then predicts the outputs
  // that will appear after the coming rising edge.
  int          mh = 0, mv = VT - 1, rem = 0;
  logic [12:0] mline = '0;
  logic        muf = 1'b0, load_pending = 1'b0;
  pkt_t        bp;
  logic        act, trig;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (load_pending) begin
        repeat (HA) fifo.push_back(mline[7:0]);
        load_pending = 1'b0;
      end
      act     = (mh < HA) && (mv < VA);
      rdempty = (fifo.size() == 0) || (act && (mv == starve_line));
      rdata   = (fifo.size() != 0) ? fifo[0] : 8'h5A;
      #1;
      bp.rreq_obs = oRREQ;
      bp.rreq_exp = act && !rdempty;
      bp.h = mh;
      bp.v = mv;
      if (rst) begin
        bp.data = 8'h00; bp.blank = 0; bp.hs = 0; bp.vs = 0; bp.clr = 0;
        bp.req = 0; bp.uf = 0; bp.line = '0;
        mh = 0; mv = VT - 1; rem = 0; mline = '0; muf = 0;
        load_pending = 0;
        fifo.delete();
      end else begin
        bp.data  = (act && !rdempty) ? rdata : 8'h00;
        bp.blank = act;
        bp.hs    = (mh >= HA + HFP) && (mh < HA + HFP + HSY);
        bp.vs    = (mv >= VA + VFP) && (mv < VA + VFP + VSY);
        bp.clr   = (mh == 0) && (mv == VA);
        trig     = (mh == HA) && ((mv + 1 < VA) || (mv == VT - 1));
        if (rem == 0 && trig) begin
          rem   = RC;
          mline = (mv == VT - 1) ? 13'd0 : 13'(mv + 1);
        end else if (rem > 0) begin
          rem--;
          if (rem == 0) load_pending = 1'b1;
        end
        bp.req  = (rem > 0);
        bp.line = mline;
        if (act && rdempty) muf = 1'b1;
        bp.uf = muf;
        if (act && !rdempty) void'(fifo.pop_front());
        if (bp.clr) fifo.delete();
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      sb.push_back(bp);
    end
  end

  task automatic test_reset();
    pkt_t p;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    #1;
    p = sb.pop_front();
    tests_run++;
    if (oVGA_DATA !== 8'h00 || oVGA_BLANK_N !== 1'b0 || oVGA_HS !== 1'b0 || oVGA_VS !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pix: data=%h blank=%b hs=%b vs=%b required 00/0/0/0", oVGA_DATA, oVGA_BLANK_N, oVGA_HS, oVGA_VS);
    end
    tests_run++;
    if (oVGA_LOAD_TO_FIFO_REQ !== 1'b0 || oVGA_LINE_TO_LOAD !== 13'd0 || oFIFO_CLR !== 1'b0 || oUNDERFLOW !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: req=%b line=%0d clr=%b uf=%b required 0/0/0/0", oVGA_LOAD_TO_FIFO_REQ, oVGA_LINE_TO_LOAD, oFIFO_CLR, oUNDERFLOW);
    end
    tests_run++;
    if (oRREQ !== 1'b0 || p.rreq_obs !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rreq: rreq=%b required 0", oRREQ);
    end
    $display("[TB] reset: outputs checked");
    rst = 1'b0;
  endtask

  // Called immediately after reset release: k counts edges since release.
  task automatic test_first_request();
    int          rise_k[2];
    logic [12:0] rise_line[2];
    int          nr = 0, high = 0;
    logic        prev = 1'b0;
    for (int k = 1; k <= HA + HT + 10; k++) begin
      @(negedge clk);
      #1;
      if (oVGA_LOAD_TO_FIFO_REQ === 1'b1 && !prev && nr < 2) begin
        rise_k[nr] = k;
        rise_line[nr] = oVGA_LINE_TO_LOAD;
        nr++;
      end
      if (nr == 1 && oVGA_LOAD_TO_FIFO_REQ === 1'b1) high++;
      prev = oVGA_LOAD_TO_FIFO_REQ;
    end
    tests_run++;
    if (nr != 2) begin
      tests_failed++;
      $display("FAIL first_req_count: saw %0d request pulses, required 2", nr);
    end else begin
      tests_run++;
      if (rise_k[0] != HA + 1 || rise_line[0] !== 13'd0) begin
        tests_failed++;
        $display("FAIL first_req: at cycle %0d line %0d, required cycle %0d line 0", rise_k[0], rise_line[0], HA + 1);
      end
      tests_run++;
      if (high != RC) begin
        tests_failed++;
        $display("FAIL first_req_width: high %0d clocks, required %0d", high, RC);
      end
      tests_run++;
      if (rise_k[1] != HA + 1 + HT || rise_line[1] !== 13'd1) begin
        tests_failed++;
        $display("FAIL second_req: at cycle %0d line %0d, required cycle %0d line 1", rise_k[1], rise_line[1], HA + 1 + HT);
      end
    end
    $display("[TB] first_request: %0d pulses, first width %0d", nr, high);
  endtask

  task automatic test_full_frame(input int nframes);
    pkt_t p;
    int   nblank = 0, nclr = 0;
    @(negedge clk);
    #1;
    sb.delete();
    for (int c = 0; c < nframes * VT * HT; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_empty: no expectation at cycle %0d", c);
        continue;
      end
      p = sb.pop_front();
      if (oVGA_DATA !== p.data || oVGA_BLANK_N !== p.blank || oVGA_HS !== p.hs || oVGA_VS !== p.vs) begin
        tests_failed++;
        $display("FAIL frame_pix h=%0d v=%0d: data=%h blank=%b hs=%b vs=%b required %h/%b/%b/%b",
                 p.h, p.v, oVGA_DATA, oVGA_BLANK_N, oVGA_HS, oVGA_VS, p.data, p.blank, p.hs, p.vs);
      end
      tests_run++;
      if (oFIFO_CLR !== p.clr || oVGA_LOAD_TO_FIFO_REQ !== p.req || oVGA_LINE_TO_LOAD !== p.line || oUNDERFLOW !== p.uf) begin
        tests_failed++;
        $display("FAIL frame_ctl h=%0d v=%0d: clr=%b req=%b line=%0d uf=%b required %b/%b/%0d/%b",
                 p.h, p.v, oFIFO_CLR, oVGA_LOAD_TO_FIFO_REQ, oVGA_LINE_TO_LOAD, oUNDERFLOW, p.clr, p.req, p.line, p.uf);
      end
      tests_run++;
      if (p.rreq_obs !== p.rreq_exp) begin
        tests_failed++;
        $display("FAIL frame_rreq h=%0d v=%0d: rreq=%b required %b", p.h, p.v, p.rreq_obs, p.rreq_exp);
      end
      if (p.blank) begin
        nblank++;
        tests_run++;
        if (oVGA_DATA !== 8'(p.v)) begin
          tests_failed++;
          $display("FAIL frame_line_value h=%0d v=%0d: data=%h required %h", p.h, p.v, oVGA_DATA, 8'(p.v));
        end
      end
      if (oFIFO_CLR === 1'b1) nclr++;
    end
    tests_run++;
    if (nblank != nframes * HA * VA) begin
      tests_failed++;
      $display("FAIL frame_blank_count: %0d active clocks, required %0d", nblank, nframes * HA * VA);
    end
    tests_run++;
    if (nclr != nframes) begin
      tests_failed++;
      $display("FAIL frame_clr_count: %0d flushes, required %0d", nclr, nframes);
    end
    tests_run++;
    if (oUNDERFLOW !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_underflow: uf=%b required 0", oUNDERFLOW);
    end
    $display("[TB] full_frame: %0d frames, %0d active clocks, %0d flushes", nframes, nblank, nclr);
  endtask

  task automatic test_sync_timing();
    int   last_fall = -10 * HT, last_hs = -1, last_clr = -1, vs_rise = -1;
    logic pb, ph, pv;
    @(negedge clk);
    #1;
    pb = oVGA_BLANK_N; ph = oVGA_HS; pv = oVGA_VS;
    for (int c = 0; c < 2 * VT * HT; c++) begin
      @(negedge clk);
      #1;
      if (pb && !oVGA_BLANK_N) last_fall = c;
      if (!ph && oVGA_HS) begin
        if (c - last_fall < HT) begin
          tests_run++;
          if (c - last_fall != HFP) begin
            tests_failed++;
            $display("FAIL hs_offset: %0d clocks after blank, required %0d", c - last_fall, HFP);
          end
        end
        if (last_hs >= 0) begin
          tests_run++;
          if (c - last_hs != HT) begin
            tests_failed++;
            $display("FAIL line_period: %0d, required %0d", c - last_hs, HT);
          end
        end
        last_hs = c;
      end
      if (ph && !oVGA_HS && last_hs >= 0) begin
        tests_run++;
        if (c - last_hs != HSY) begin
          tests_failed++;
          $display("FAIL hs_width: %0d, required %0d", c - last_hs, HSY);
        end
      end
      if (oFIFO_CLR === 1'b1) begin
        if (last_clr >= 0) begin
          tests_run++;
          if (c - last_clr != VT * HT) begin
            tests_failed++;
            $display("FAIL frame_period: %0d, required %0d", c - last_clr, VT * HT);
          end
        end
        last_clr = c;
      end
      if (!pv && oVGA_VS) begin
        if (last_clr >= 0) begin
          tests_run++;
          if (c - last_clr != VFP * HT) begin
            tests_failed++;
            $display("FAIL vs_offset: %0d after flush, required %0d", c - last_clr, VFP * HT);
          end
        end
        vs_rise = c;
      end
      if (pv && !oVGA_VS && vs_rise >= 0) begin
        tests_run++;
        if (c - vs_rise != VSY * HT) begin
          tests_failed++;
          $display("FAIL vs_width: %0d, required %0d", c - vs_rise, VSY * HT);
        end
      end
      pb = oVGA_BLANK_N; ph = oVGA_HS; pv = oVGA_VS;
    end
    $display("[TB] sync_timing: two frames measured");
  endtask

  task automatic test_flush_boundaries();
    pkt_t p;
    int   nclr = 0, nreq = 0;
    logic prev;
    @(negedge clk);
    #1;
    sb.delete();
    prev = oVGA_LOAD_TO_FIFO_REQ;
    for (int c = 0; c < VT * HT; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_empty: no expectation at cycle %0d", c);
        continue;
      end
      p = sb.pop_front();
      if (oFIFO_CLR === 1'b1) begin
        nclr++;
        tests_run++;
        if (p.h != 0 || p.v != VA || oVGA_LOAD_TO_FIFO_REQ === 1'b1) begin
          tests_failed++;
          $display("FAIL clr_position: flush at h=%0d v=%0d req=%b, required h=0 v=%0d req=0", p.h, p.v, oVGA_LOAD_TO_FIFO_REQ, VA);
        end
      end
      if (oVGA_LOAD_TO_FIFO_REQ === 1'b1 && !prev) begin
        nreq++;
        tests_run++;
        if (!((p.v < VA - 1) || (p.v == VT - 1))) begin
          tests_failed++;
          $display("FAIL req_line_window: request issued on v=%0d", p.v);
        end
      end
      tests_run++;
      if (oVGA_LINE_TO_LOAD > 13'(VA - 1)) begin
        tests_failed++;
        $display("FAIL line_max: line=%0d, required <= %0d", oVGA_LINE_TO_LOAD, VA - 1);
      end
      prev = oVGA_LOAD_TO_FIFO_REQ;
    end
    tests_run++;
    if (nclr != 1 || nreq != VA) begin
      tests_failed++;
      $display("FAIL frame_counts: %0d flushes %0d requests, required 1 and %0d", nclr, nreq, VA);
    end
    $display("[TB] flush_boundaries: %0d flushes, %0d requests", nclr, nreq);
  endtask

  task automatic test_starve();
    pkt_t p;
    int   starved = 0;
    @(negedge clk);
    #1;
    sb.delete();
    starve_line = 5;
    for (int c = 0; c < 2 * VT * HT; c++) begin
      @(negedge clk);
      #1;
      if (c == VT * HT) starve_line = -1;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_empty: no expectation at cycle %0d", c);
        continue;
      end
      p = sb.pop_front();
      if (c < VT * HT && p.v == 5 && p.h < HA) begin
        starved++;
        tests_run++;
        if (p.rreq_obs !== 1'b0 || oVGA_DATA !== 8'h00) begin
          tests_failed++;
          $display("FAIL starve_line h=%0d: rreq=%b data=%h required 0/00", p.h, p.rreq_obs, oVGA_DATA);
        end
      end
      tests_run++;
      if (oVGA_DATA !== p.data || oUNDERFLOW !== p.uf || p.rreq_obs !== p.rreq_exp) begin
        tests_failed++;
        $display("FAIL starve_sb h=%0d v=%0d: data=%h uf=%b rreq=%b required %h/%b/%b",
                 p.h, p.v, oVGA_DATA, oUNDERFLOW, p.rreq_obs, p.data, p.uf, p.rreq_exp);
      end
      if (c >= VT * HT) begin
        tests_run++;
        if (oUNDERFLOW !== 1'b1) begin
          tests_failed++;
          $display("FAIL underflow_hold: uf=%b required 1 at cycle %0d", oUNDERFLOW, c);
        end
      end
    end
    tests_run++;
    if (starved != HA) begin
      tests_failed++;
      $display("FAIL starve_window: %0d starved clocks, required %0d", starved, HA);
    end
    $display("[TB] starve: %0d starved clocks, uf=%b", starved, oUNDERFLOW);
  endtask

  task automatic test_mid_reset();
    int   rises = 0, k_rise = -1, high = 0;
    logic prev = 1'b0;
    bit   done = 1'b0;
    @(negedge clk);
    #1;
    rst4 = 1'b0;
    for (int k = 1; k <= 3 * HT && !done; k++) begin
      @(negedge clk);
      #1;
      if (req4 === 1'b1 && !prev) begin
        rises++;
        if (rises == 2) done = 1'b1;
      end
      prev = req4;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL mid_reset_wait: saw %0d requests, required 2", rises);
    end else begin
      tests_run++;
      if (line4 !== 13'd1 || uf4 !== 1'b1) begin
        tests_failed++;
        $display("FAIL mid_reset_pre: line=%0d uf=%b required 1/1", line4, uf4);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (req4 !== 1'b1) begin
        tests_failed++;
        $display("FAIL mid_reset_hold: req=%b required 1", req4);
      end
      rst4 = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if (req4 !== 1'b0 || uf4 !== 1'b0 || blank4 !== 1'b0 || line4 !== 13'd0 || clr4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_clear: req=%b uf=%b blank=%b line=%0d clr=%b required all 0",
                 req4, uf4, blank4, line4, clr4);
      end
      rst4 = 1'b0;
      prev = 1'b0;
      for (int k = 1; k <= HA + 10; k++) begin
        @(negedge clk);
        #1;
        if (req4 === 1'b1 && !prev && k_rise < 0) k_rise = k;
        if (k_rise >= 0 && req4 === 1'b1) high++;
        prev = req4;
      end
      tests_run++;
      if (k_rise != HA + 1 || high != RC4 || line4 !== 13'd0) begin
        tests_failed++;
        $display("FAIL mid_reset_restart: rise at %0d width %0d line %0d, required %0d/%0d/0",
                 k_rise, high, line4, HA + 1, RC4);
      end
    end
    $display("[TB] mid_reset: restart request at cycle %0d width %0d", k_rise, high);
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_full_frame(2);
    test_sync_timing();
    test_flush_boundaries();
    test_starve();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
